// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings and
// the operand/carry-in rules each op applies to the adder.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Subtracting forms use A + ~B + cin, so they invert B before the adder.
  function automatic logic op_inverts_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  function automatic logic op_carry_in(input op_e op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry segment of the pipelined adder: a SEG_W-bit ripple add with
// carry out and a zero flag for the segment's sum.
module addsub_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             zero
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  assign zero        = (sum == '0);

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement ADD/SUB/ADC/SBB unit: the carry chain is cut into
// STAGES registered segments, with a valid/ready stream that stalls as a whole.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [TAG_W-1:0] out_tag
);

  import addsub_pkg::*;

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int SEG_W       = WIDTH / SAFE_STAGES;

  if ((STAGES < 1) || (WIDTH % SAFE_STAGES != 0)) begin : g_bad_cfg
    $fatal(1, "addsub_pipe: WIDTH must be a positive multiple of STAGES");
  end

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             advance;

  assign op      = op_e'(in_op);
  assign b_eff   = op_inverts_b(op) ? ~in_b : in_b;
  assign cin_eff = op_carry_in(op, in_cin);

  // The whole pipe moves together: it only freezes when a finished result is
  // waiting and the consumer is not taking it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // Operand B only needs the slices that later stages have not consumed yet.
    localparam int BH_W = WIDTH - s * SEG_W;

    logic [WIDTH-1:0] a_in;
    logic [BH_W-1:0]  bh_in;
    logic             c_in;
    logic             z_in;
    logic             vld_in;
    logic [TAG_W-1:0] tag_in;

    logic [SEG_W-1:0] sum;
    logic             cout;
    logic             zero;
    logic [WIDTH-1:0] ar_d;

    // ar_q: finished result bits below this stage's boundary, A operand above.
    logic             vld_q;
    logic             cy_q;
    logic             zf_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] ar_q;

    if (s == 0) begin : g_head
      assign a_in   = in_a;
      assign bh_in  = b_eff;
      assign c_in   = cin_eff;
      assign z_in   = 1'b1;
      assign vld_in = in_valid;
      assign tag_in = in_tag;
    end else begin : g_body
      assign a_in   = g_stage[s-1].ar_q;
      assign bh_in  = g_stage[s-1].g_fwd.br_q;
      assign c_in   = g_stage[s-1].cy_q;
      assign z_in   = g_stage[s-1].zf_q;
      assign vld_in = g_stage[s-1].vld_q;
      assign tag_in = g_stage[s-1].tag_q;
    end

    addsub_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a    (a_in[s*SEG_W +: SEG_W]),
      .b    (bh_in[SEG_W-1:0]),
      .cin  (c_in),
      .sum  (sum),
      .cout (cout),
      .zero (zero)
    );

    always_comb begin
      // NOTE: full default before the slice overwrite, so no bit of ar_d can infer a latch.
      ar_d                    = a_in;
      ar_d[s*SEG_W +: SEG_W]  = sum;
    end

    always_ff @(posedge clk) begin
      // NOTE: data registers are reset as well as valid bits, so every out_* reads 0 after reset.
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        zf_q  <= 1'b0;
        tag_q <= '0;
        ar_q  <= '0;
      end else if (advance) begin
        // NOTE: non-blocking updates, so each stage captures its neighbour's pre-edge value.
        vld_q <= vld_in;
        cy_q  <= cout;
        zf_q  <= z_in && zero;
        tag_q <= tag_in;
        ar_q  <= ar_d;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [BH_W-SEG_W-1:0] br_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          br_q <= '0;
        end else if (advance) begin
          br_q <= bh_in[BH_W-1:SEG_W];
        end
      end
    end else begin : g_tail
      // The last segment holds both operand MSBs, so signed overflow is decided here.
      logic v_d;
      logic v_q;

      assign v_d = (a_in[WIDTH-1] == bh_in[SEG_W-1]) && (sum[SEG_W-1] != a_in[WIDTH-1]);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign out_r     = g_stage[STAGES-1].ar_q;
  assign out_c     = g_stage[STAGES-1].cy_q;
  assign out_z     = g_stage[STAGES-1].zf_q;
  assign out_tag   = g_stage[STAGES-1].tag_q;
  assign out_v     = g_stage[STAGES-1].g_tail.v_q;
  assign out_n     = out_r[WIDTH-1];

endmodule
